// File: rtl/uhci_frame_sched_if.sv
// ============================================================================
// Module : uhci_frame_sched_if
// Brief  : Control/strobe bundle between the UHCI frame scheduler and its peers
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uhci_frame_sched_if #(
  parameter int FLEN_W  = 14,
  parameter int FNUM_W  = 11,
  parameter int FLIDX_W = 10,
  parameter int OVR_W   = 8
);
  logic               run;
  logic               err_halt;
  logic [FLEN_W-1:0]  frame_len;
  logic               fnum_wr_en;
  logic [FNUM_W-1:0]  fnum_wr_data;
  logic               td_done;

  logic               sof;
  logic               pre_sof;
  logic [FNUM_W-1:0]  frame_num;
  logic [FLIDX_W-1:0] frame_list_index;
  logic [10:0]        frame_num_sie;
  logic               rollover;
  logic               overrun;
  logic [OVR_W-1:0]   overrun_cnt;
  logic               halted;
  logic [1:0]         halt_src;

  // RegFile / error logic / transaction side
  modport master (
    output run, err_halt, frame_len, fnum_wr_en, fnum_wr_data, td_done,
    input  sof, pre_sof, frame_num, frame_list_index, frame_num_sie,
           rollover, overrun, overrun_cnt, halted, halt_src
  );

  // Scheduler side
  modport slave (
    input  run, err_halt, frame_len, fnum_wr_en, fnum_wr_data, td_done,
    output sof, pre_sof, frame_num, frame_list_index, frame_num_sie,
           rollover, overrun, overrun_cnt, halted, halt_src
  );
endinterface

`default_nettype wire

// File: rtl/uhci_frame_sched.sv
// ============================================================================
// Module : uhci_frame_sched
// Brief  : UHCI 1 ms frame timebase: SOF/pre-SOF strobes, frame number, overrun
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uhci_frame_sched #(
  parameter int FLEN_W   = 14,
  parameter int FLEN_RST = 11999,
  parameter int PRE_LEAD = 64,
  parameter int FNUM_W   = 11,
  parameter int FLIDX_W  = 10,
  parameter int OVR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uhci_frame_sched_if.slave    bus
);

  typedef enum logic [0:0] {
    S_HALTED = 1'b0,
    S_RUN    = 1'b1
  } state_t;

  localparam logic [FLEN_W-1:0] c_MIN_LEN  = FLEN_W'(PRE_LEAD + 2);
  localparam logic [FLEN_W-1:0] c_PRE_LEAD = FLEN_W'(PRE_LEAD);
  localparam logic [1:0]        c_SRC_SW   = 2'b01;
  localparam logic [1:0]        c_SRC_ERR  = 2'b10;

  if (FNUM_W < 11 || FNUM_W > 16 || FLIDX_W > FNUM_W ||
      FLEN_RST >= (2 ** FLEN_W) || PRE_LEAD + 2 >= (2 ** FLEN_W)) begin : g_param_check
    $error("uhci_frame_sched: illegal parameter combination");
  end

  state_t              r_state, w_state_nxt;
  logic [FLEN_W-1:0]   r_cnt, w_cnt_nxt;
  logic                r_td_seen, w_td_seen_nxt;
  logic                r_sof, w_sof_nxt;
  logic                r_pre_sof, w_pre_sof_nxt;
  logic                r_rollover, w_rollover_nxt;
  logic                r_overrun, w_overrun_nxt;
  logic [FNUM_W-1:0]   r_fnum, w_fnum_nxt;
  logic [OVR_W-1:0]    r_ovr_cnt, w_ovr_cnt_nxt;
  logic [1:0]          r_halt_src, w_halt_src_nxt;
  logic                r_halted;

  logic [FLEN_W-1:0]   w_eff_len;
  logic [FNUM_W-1:0]   w_fnum_inc;

  // Short programmed lengths would put pre_sof at or before the sof itself
  assign w_eff_len  = (bus.frame_len < c_MIN_LEN) ? c_MIN_LEN : bus.frame_len;
  assign w_fnum_inc = r_fnum + FNUM_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HALTED;
      r_cnt      <= '0;
      r_td_seen  <= 1'b0;
      r_sof      <= 1'b0;
      r_pre_sof  <= 1'b0;
      r_rollover <= 1'b0;
      r_overrun  <= 1'b0;
      r_fnum     <= '0;
      r_ovr_cnt  <= '0;
      r_halt_src <= 2'b00;
      r_halted   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_td_seen  <= w_td_seen_nxt;
      r_sof      <= w_sof_nxt;
      r_pre_sof  <= w_pre_sof_nxt;
      r_rollover <= w_rollover_nxt;
      r_overrun  <= w_overrun_nxt;
      r_fnum     <= w_fnum_nxt;
      r_ovr_cnt  <= w_ovr_cnt_nxt;
      r_halt_src <= w_halt_src_nxt;
      r_halted   <= (w_state_nxt == S_HALTED);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_td_seen_nxt  = r_td_seen;
    w_sof_nxt      = 1'b0;
    w_pre_sof_nxt  = 1'b0;
    w_rollover_nxt = 1'b0;
    w_overrun_nxt  = 1'b0;
    w_fnum_nxt     = r_fnum;
    w_ovr_cnt_nxt  = r_ovr_cnt;
    w_halt_src_nxt = r_halt_src;

    case (r_state)
      S_HALTED: begin
        w_cnt_nxt     = '0;
        w_td_seen_nxt = 1'b0;
        if (bus.fnum_wr_en) begin
          w_fnum_nxt = bus.fnum_wr_data;
        end
        // The first frame after a start keeps the current frame number
        if (bus.run && !bus.err_halt) begin
          w_state_nxt   = S_RUN;
          w_sof_nxt     = 1'b1;
          w_cnt_nxt     = w_eff_len;
          w_ovr_cnt_nxt = '0;
        end
      end

      S_RUN: begin
        if (bus.err_halt) begin
          w_state_nxt    = S_HALTED;
          w_cnt_nxt      = '0;
          w_td_seen_nxt  = 1'b0;
          w_halt_src_nxt = c_SRC_ERR;
        end else if (r_cnt == '0) begin
          if (!r_td_seen && !bus.td_done) begin
            w_overrun_nxt = 1'b1;
            if (r_ovr_cnt != '1) begin
              w_ovr_cnt_nxt = r_ovr_cnt + OVR_W'(1);
            end
          end
          w_td_seen_nxt = 1'b0;
          if (bus.run) begin
            w_sof_nxt      = 1'b1;
            w_fnum_nxt     = w_fnum_inc;
            w_rollover_nxt = (w_fnum_inc[FLIDX_W-1:0] == '0);
            w_cnt_nxt      = w_eff_len;
          end else begin
            w_state_nxt    = S_HALTED;
            w_halt_src_nxt = c_SRC_SW;
          end
        end else begin
          w_cnt_nxt     = r_cnt - FLEN_W'(1);
          w_pre_sof_nxt = (r_cnt == c_PRE_LEAD);
          if (bus.td_done) begin
            w_td_seen_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_HALTED;
      end
    endcase
  end

  assign bus.sof              = r_sof;
  assign bus.pre_sof          = r_pre_sof;
  assign bus.frame_num        = r_fnum;
  assign bus.frame_list_index = r_fnum[FLIDX_W-1:0];
  assign bus.frame_num_sie    = r_fnum[10:0];
  assign bus.rollover         = r_rollover;
  assign bus.overrun          = r_overrun;
  assign bus.overrun_cnt      = r_ovr_cnt;
  assign bus.halted           = r_halted;
  assign bus.halt_src         = r_halt_src;

endmodule

`default_nettype wire
